// File: rtl/prng_pkg.sv
// rtl/prng_pkg.sv - shared state encoding and default constants for the PRNG health monitor
package prng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_EVAL  = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam int          DEF_WINDOW    = 256;
    localparam int          DEF_REP_LIMIT = 4;
    localparam int          DEF_ONES_LO   = 3900;
    localparam int          DEF_ONES_HI   = 4292;
    localparam logic [31:0] DEF_SEED_CA   = 32'h0000_0001;
    localparam logic [31:0] DEF_SEED_LFSR = 32'hACE1_2468;

endpackage

// File: rtl/prng_popcount.sv
// rtl/prng_popcount.sv - combinational ones count of an N-bit word
module prng_popcount #(
    parameter int N  = 32,
    parameter int PW = $clog2(N + 1)
) (
    input  logic [N-1:0]  data,
    output logic [PW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + PW'(data[i]);
        end
    end

endmodule

// File: rtl/prng_health_monitor.sv
// rtl/prng_health_monitor.sv - repetition-count and monobit health tests on a PRNG word stream
module prng_health_monitor
    import prng_pkg::*;
#(
    parameter int N         = 32,
    parameter int WINDOW    = DEF_WINDOW,
    parameter int REP_LIMIT = DEF_REP_LIMIT,
    parameter int ONES_LO   = DEF_ONES_LO,
    parameter int ONES_HI   = DEF_ONES_HI,
    parameter int CW        = $clog2(WINDOW * N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          clear_fail,
    input  logic          s_valid,
    input  logic [N-1:0]  s_data,
    output logic          s_ready,
    output logic          window_done,
    output logic [CW-1:0] window_ones,
    output logic          mono_fail,
    output logic          rep_fail,
    output logic          busy
);

    localparam int PW = $clog2(N + 1);
    localparam int WC = $clog2(WINDOW + 1);
    localparam int RW = $clog2(REP_LIMIT + 1);

    state_t        state, state_n;
    logic [CW-1:0] ones_acc;
    logic [CW-1:0] ones_sum;
    logic [WC-1:0] word_cnt;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_cnt_n;
    logic [N-1:0]  last_word;
    logic          last_valid;
    logic [PW-1:0] pop;
    logic          accept;
    logic          run_accept;
    logic          rep_hit;
    logic          last_of_window;
    logic          mono_bad;
    logic          set_rep;
    logic          set_mono;

    prng_popcount #(.N(N), .PW(PW)) u_popcount (
        .data  (s_data),
        .count (pop)
    );

    assign s_ready        = (state == ST_RUN) || (state == ST_ALARM);
    assign window_done    = (state == ST_EVAL);
    assign busy           = (state == ST_RUN) || (state == ST_EVAL);
    assign accept         = s_valid && s_ready;
    assign ones_sum       = ones_acc + CW'(pop);
    assign rep_cnt_n      = (last_valid && (s_data == last_word)) ? rep_cnt + RW'(1) : RW'(1);
    assign rep_hit        = (rep_cnt_n == RW'(REP_LIMIT));
    assign last_of_window = (word_cnt == WC'(WINDOW - 1));
    assign mono_bad       = (window_ones < CW'(ONES_LO)) || (window_ones > CW'(ONES_HI));
    // with enable low the accept is still taken but may not fail or close the window
    assign run_accept     = (state == ST_RUN) && enable && accept;
    assign set_rep        = run_accept && rep_hit;
    assign set_mono       = (state == ST_EVAL) && mono_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (enable) state_n = ST_RUN;
            end
            ST_RUN: begin
                if (!enable)                          state_n = ST_IDLE;
                else if (set_rep)                     state_n = ST_ALARM;
                else if (run_accept && last_of_window) state_n = ST_EVAL;
            end
            ST_EVAL: begin
                if (mono_bad)    state_n = ST_ALARM;
                else if (enable) state_n = ST_RUN;
                else             state_n = ST_IDLE;
            end
            ST_ALARM: begin
                if (clear_fail) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ones_acc    <= '0;
            word_cnt    <= '0;
            rep_cnt     <= '0;
            last_word   <= '0;
            last_valid  <= 1'b0;
            window_ones <= '0;
            mono_fail   <= 1'b0;
            rep_fail    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ones_acc   <= '0;
                    word_cnt   <= '0;
                    rep_cnt    <= '0;
                    last_valid <= 1'b0;
                end
                ST_RUN: begin
                    if (accept) begin
                        ones_acc   <= ones_sum;
                        word_cnt   <= word_cnt + WC'(1);
                        rep_cnt    <= rep_cnt_n;
                        last_word  <= s_data;
                        last_valid <= 1'b1;
                        if (run_accept && !rep_hit && last_of_window) begin
                            window_ones <= ones_sum;
                        end
                    end
                end
                // repetition state deliberately survives the window boundary
                ST_EVAL: begin
                    ones_acc <= '0;
                    word_cnt <= '0;
                end
                default: ;
            endcase
            rep_fail  <= set_rep  || (rep_fail  && !clear_fail);
            mono_fail <= set_mono || (mono_fail && !clear_fail);
        end
    end

endmodule

// File: tb/tb_prng_health_monitor.sv
// tb/tb_prng_health_monitor.sv - directed self-checking bench for prng_health_monitor
module tb_prng_health_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear_fail = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic        window_done;
    logic [13:0] window_ones;
    logic        mono_fail;
    logic        rep_fail;
    logic        busy;

    int total = 0;
    int passed = 0;
    int failed = 0;
    int done_cnt = 0;
    int done_base;

    prng_health_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .clear_fail  (clear_fail),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .window_done (window_done),
        .window_ones (window_ones),
        .mono_fail   (mono_fail),
        .rep_fail    (rep_fail),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (window_done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        logic rdy;
        int   waits;
        s_valid = 1'b1;
        s_data  = d;
        waits   = 0;
        do begin
            rdy = s_ready;
            tick();
            waits++;
        end while (!rdy && waits < 20);
        if (!rdy) check("send_accept", {31'b0, rdy}, 32'd1);
        s_valid = 1'b0;
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] w, input int k);
        logic [63:0] dbl;
        dbl = {w, w} << k;
        return dbl[63:32];
    endfunction

    function automatic logic [31:0] alt(input int i);
        return (i % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
    endfunction

    initial begin
        // reset state
        tick();
        tick();
        check("rst_ready", {31'b0, s_ready}, 0);
        check("rst_done", {31'b0, window_done}, 0);
        check("rst_ones", {18'b0, window_ones}, 0);
        check("rst_flags", {30'b0, mono_fail, rep_fail}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        reset = 1'b0;
        tick();

        // alternating pattern: exactly half ones
        enable = 1'b1;
        tick();
        check("run_busy", {31'b0, busy}, 1);
        done_base = done_cnt;
        for (int i = 0; i < 255; i++) send(alt(i));
        tick();
        check("alt_no_early_done", done_cnt - done_base, 0);
        send(alt(255));
        check("alt_done", {31'b0, window_done}, 1);
        check("alt_ones", {18'b0, window_ones}, 4096);
        tick();
        check("alt_done_once", done_cnt - done_base, 1);
        check("alt_back_run", {30'b0, busy, s_ready}, 3);
        check("alt_no_fail", {30'b0, mono_fail, rep_fail}, 0);

        // rotations of 0xFFFFFFF0: 28 ones per word, density too high
        for (int i = 0; i < 256; i++) send(rotl(32'hFFFF_FFF0, i % 32));
        check("hi_done", {31'b0, window_done}, 1);
        check("hi_ones", {18'b0, window_ones}, 7168);
        tick();
        check("hi_mono", {31'b0, mono_fail}, 1);
        check("hi_alarm", {30'b0, busy, s_ready}, 1);
        enable = 1'b0;
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
        check("hi_cleared", {30'b0, mono_fail, rep_fail}, 0);
        check("hi_idle", {30'b0, busy, s_ready}, 0);
        tick();
        check("hi_stay_idle", {30'b0, busy, s_ready}, 0);

        // repetition: three repeats then a different word pass, four repeats fail
        enable = 1'b1;
        done_base = done_cnt;
        send(32'h1);
        send(32'h2);
        for (int i = 0; i < 3; i++) send(32'h1234_5678);
        send(32'h1234_5679);
        check("rep3_ok", {31'b0, rep_fail}, 0);
        for (int i = 0; i < 3; i++) send(32'h1234_5678);
        check("rep_before_4th", {31'b0, rep_fail}, 0);
        send(32'h1234_5678);
        check("rep4_fail", {31'b0, rep_fail}, 1);
        check("rep4_alarm", {30'b0, busy, s_ready}, 1);
        tick();
        check("rep_no_done", done_cnt - done_base, 0);
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
        check("rep_cleared", {31'b0, rep_fail}, 0);

        // repeats straddling a window boundary
        for (int i = 0; i < 254; i++) send(alt(i));
        send(32'hDEAD_BEEF);
        send(32'hDEAD_BEEF);
        check("bnd_done", {31'b0, window_done}, 1);
        check("bnd_ones", {18'b0, window_ones}, 4112);
        send(32'hDEAD_BEEF);
        check("bnd_no_mono", {30'b0, mono_fail, rep_fail}, 0);
        send(32'hDEAD_BEEF);
        check("bnd_rep_fail", {31'b0, rep_fail}, 1);
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;

        // gapped stream with an aborted window
        done_base = done_cnt;
        for (int i = 0; i < 100; i++) begin
            send(alt(i));
            repeat ($urandom_range(0, 2)) tick();
        end
        enable = 1'b0;
        tick();
        check("abort_idle", {30'b0, busy, s_ready}, 0);
        tick();
        check("abort_no_done", done_cnt - done_base, 0);
        check("abort_ones_kept", {18'b0, window_ones}, 4112);
        enable = 1'b1;
        for (int i = 0; i < 255; i++) begin
            send(alt(i));
            repeat ($urandom_range(0, 2)) tick();
        end
        check("gap_no_early_done", done_cnt - done_base, 0);
        send(alt(255));
        check("gap_done", {31'b0, window_done}, 1);
        check("gap_ones", {18'b0, window_ones}, 4096);

        // asynchronous reset mid-window
        for (int i = 0; i < 200; i++) send(alt(i));
        #2;
        reset = 1'b1;
        #1;
        check("arst_ones", {18'b0, window_ones}, 0);
        check("arst_outs", {27'b0, s_ready, window_done, mono_fail, rep_fail, busy}, 0);
        tick();
        reset = 1'b0;
        tick();

        // failure and clear in the same cycle: failure wins
        for (int i = 0; i < 3; i++) send(32'h0000_0077);
        check("coin_pre", {31'b0, rep_fail}, 0);
        clear_fail = 1'b1;
        send(32'h0000_0077);
        clear_fail = 1'b0;
        check("coin_fail_wins", {31'b0, rep_fail}, 1);
        enable = 1'b0;
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
        check("coin_cleared", {31'b0, rep_fail}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
